// File: rtl/reg_scoreboard.sv
// reg_scoreboard: dual-issue RAW/capacity hazard scoreboard for the
// 4-read/2-write register file. Counts in-flight writes per register and
// decides each cycle whether decode lanes 0 (older) and 1 (younger) issue.
// Optional build macro: SB_WB_BYPASS_EN lets a source whose single pending
// write is being written back this cycle count as ready. The register file
// forwards same-cycle write data to its read ports.
module reg_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic               sb_in_clk,
  input  logic               sb_in_rstL,
  input  logic               id0_valid,
  input  logic [ADDR_W-1:0]  id0_rs1,
  input  logic [ADDR_W-1:0]  id0_rs2,
  input  logic               id0_we,
  input  logic [ADDR_W-1:0]  id0_rd,
  input  logic               id1_valid,
  input  logic [ADDR_W-1:0]  id1_rs1,
  input  logic [ADDR_W-1:0]  id1_rs2,
  input  logic               id1_we,
  input  logic [ADDR_W-1:0]  id1_rd,
  input  logic               ex_ready,
  input  logic               wb0_we,
  input  logic [ADDR_W-1:0]  wb0_rd,
  input  logic               wb1_we,
  input  logic [ADDR_W-1:0]  wb1_rd,
  input  logic               flush,
  output logic               issue0,
  output logic               issue1,
  output logic [REG_NUM-1:0] busy_vec,
  output logic [31:0]        stall_cnt,
  output logic               err_underflow
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   pend     [REG_NUM];
  logic [CNT_W-1:0]   pend_nxt [REG_NUM];
  logic [REG_NUM-1:0] src_ok;
  logic               err_nxt;
  logic               cap0, cap1, raw01, same_rd;
  logic [CNT_W:0]     pend1_ext;
  logic [1:0]         inc, dec;
  logic [CNT_W:0]     sum;

  // Saturating increment for the stall counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Subtraction that clamps at zero instead of wrapping.
  function automatic logic [CNT_W:0] clamp_sub(input logic [CNT_W:0] a,
                                               input logic [CNT_W:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  // A source register is ready when it is r0 or has no write in flight.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      src_ok[r] = (r == 0) || (pend[r] == '0);
`ifdef SB_WB_BYPASS_EN
      if ((pend[r] == CNT_W'(1)) &&
          ((wb0_we && (wb0_rd == ADDR_W'(r))) || (wb1_we && (wb1_rd == ADDR_W'(r)))))
        src_ok[r] = 1'b1;
`endif
    end
  end

  // Issue decision: lane 1 only behind lane 0, blocked by its RAW on lane 0.
  always_comb begin
    cap0      = !id0_we || (id0_rd == '0) || (pend[id0_rd] != MAX);
    same_rd   = id0_we && (id1_rd == id0_rd);
    pend1_ext = {1'b0, pend[id1_rd]} + {{CNT_W{1'b0}}, same_rd};
    cap1      = !id1_we || (id1_rd == '0) || (pend1_ext < {1'b0, MAX});
    raw01     = id0_we && (id0_rd != '0) &&
                ((id1_rs1 == id0_rd) || (id1_rs2 == id0_rd));
    issue0    = id0_valid && ex_ready && !flush &&
                src_ok[id0_rs1] && src_ok[id0_rs2] && cap0;
    issue1    = issue0 && id1_valid && src_ok[id1_rs1] && src_ok[id1_rs2] &&
                !raw01 && cap1;
  end

  // Next pending counts: issues add, writebacks subtract, flush clears.
  always_comb begin
    err_nxt     = err_underflow;
    inc         = '0;
    dec         = '0;
    sum         = '0;
    pend_nxt[0] = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      inc = {1'b0, issue0 && id0_we && (id0_rd == ADDR_W'(r))} +
            {1'b0, issue1 && id1_we && (id1_rd == ADDR_W'(r))};
      dec = {1'b0, wb0_we && (wb0_rd == ADDR_W'(r))} +
            {1'b0, wb1_we && (wb1_rd == ADDR_W'(r))};
      sum = {1'b0, pend[r]} + (CNT_W+1)'(inc);
      if (flush) begin
        pend_nxt[r] = '0;
      end else begin
        if (sum < (CNT_W+1)'(dec)) err_nxt = 1'b1;
        pend_nxt[r] = CNT_W'(clamp_sub(sum, (CNT_W+1)'(dec)));
      end
    end
  end

  // Busy flags mirror nonzero pending counts; r0 is never busy.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++)
      busy_vec[r] = (r != 0) && (pend[r] != '0);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge sb_in_clk or negedge sb_in_rstL) begin
    if (!sb_in_rstL) begin
      for (int r = 0; r < REG_NUM; r++) pend[r] <= '0;
      stall_cnt     <= '0;
      err_underflow <= 1'b0;
    end else begin
      pend          <= pend_nxt;
      err_underflow <= err_nxt;
      if (id0_valid && ex_ready && !issue0 && !flush)
        stall_cnt <= sat_inc32(stall_cnt);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed scenarios plus randomized traffic
// checked by a queue-based scoreboard against an integer reference model.
module tb_reg_scoreboard;
  localparam int RN   = 32;
  localparam int MAXM = 3;
`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic sb_in_clk, sb_in_rstL;
  logic id0_valid, id0_we, id1_valid, id1_we, ex_ready;
  logic [4:0] id0_rs1, id0_rs2, id0_rd, id1_rs1, id1_rs2, id1_rd;
  logic wb0_we, wb1_we, flush;
  logic [4:0] wb0_rd, wb1_rd;
  logic issue0, issue1, err_underflow;
  logic [31:0] busy_vec, stall_cnt;

  reg_scoreboard dut (
    .sb_in_clk(sb_in_clk), .sb_in_rstL(sb_in_rstL),
    .id0_valid(id0_valid), .id0_rs1(id0_rs1), .id0_rs2(id0_rs2),
    .id0_we(id0_we), .id0_rd(id0_rd),
    .id1_valid(id1_valid), .id1_rs1(id1_rs1), .id1_rs2(id1_rs2),
    .id1_we(id1_we), .id1_rd(id1_rd),
    .ex_ready(ex_ready),
    .wb0_we(wb0_we), .wb0_rd(wb0_rd), .wb1_we(wb1_we), .wb1_rd(wb1_rd),
    .flush(flush),
    .issue0(issue0), .issue1(issue1), .busy_vec(busy_vec),
    .stall_cnt(stall_cnt), .err_underflow(err_underflow)
  );

  initial begin
    sb_in_clk = 1'b0;
    forever #5 sb_in_clk = ~sb_in_clk;
  end

  typedef struct packed {
    logic        i0;
    logic        i1;
    logic [31:0] busy;
    logic [31:0] stall;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          pend_m[RN];
  int unsigned stall_m;
  bit          err_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic bit ok_m(input int r);
    if (r == 0 || pend_m[r] == 0) return 1'b1;
    if (BYP && pend_m[r] == 1 &&
        ((wb0_we && int'(wb0_rd) == r) || (wb1_we && int'(wb1_rd) == r)))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < RN; r++) pend_m[r] = 0;
    stall_m = 0;
    err_m   = 1'b0;
  endfunction

  task automatic idle();
    id0_valid = 0; id0_rs1 = 0; id0_rs2 = 0; id0_we = 0; id0_rd = 0;
    id1_valid = 0; id1_rs1 = 0; id1_rs2 = 0; id1_we = 0; id1_rd = 0;
    ex_ready = 0; wb0_we = 0; wb0_rd = 0; wb1_we = 0; wb1_rd = 0; flush = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then
  // advance the model to the state after the coming clock edge.
  task automatic step();
    bit   e0, e1, raw;
    int   dec[RN];
    int   extra;
    exp_t e;
    e0 = id0_valid && ex_ready && !flush && ok_m(int'(id0_rs1)) && ok_m(int'(id0_rs2)) &&
         (!id0_we || id0_rd == 0 || pend_m[id0_rd] < MAXM);
    raw = id0_we && id0_rd != 0 && (id1_rs1 == id0_rd || id1_rs2 == id0_rd);
    extra = (id0_we && id0_rd == id1_rd) ? 1 : 0;
    e1 = e0 && id1_valid && ok_m(int'(id1_rs1)) && ok_m(int'(id1_rs2)) && !raw &&
         (!(id1_we && id1_rd != 0) || pend_m[id1_rd] + extra < MAXM);
    e.i0 = e0;
    e.i1 = e1;
    e.busy = '0;
    for (int r = 1; r < RN; r++) e.busy[r] = (pend_m[r] != 0);
    e.stall = stall_m;
    e.err = err_m;
    q.push_back(e);
    if (flush) begin
      for (int r = 0; r < RN; r++) pend_m[r] = 0;
    end else begin
      if (e0 && id0_we && id0_rd != 0) pend_m[id0_rd]++;
      if (e1 && id1_we && id1_rd != 0) pend_m[id1_rd]++;
      for (int r = 0; r < RN; r++) dec[r] = 0;
      if (wb0_we && wb0_rd != 0) dec[wb0_rd]++;
      if (wb1_we && wb1_rd != 0) dec[wb1_rd]++;
      for (int r = 1; r < RN; r++) begin
        if (pend_m[r] < dec[r]) begin
          pend_m[r] = 0;
          err_m = 1'b1;
        end else begin
          pend_m[r] -= dec[r];
        end
      end
    end
    if (id0_valid && ex_ready && !e0 && !flush && stall_m != 32'hFFFF_FFFF) stall_m++;
    @(posedge sb_in_clk);
    #1;
  endtask

  // Reset asserted between clock edges; state must clear without a clock.
  task automatic reset_mid();
    idle();
    #6;
    sb_in_rstL = 1'b0;
    #1;
    chk("rst_stall", stall_cnt, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_err", {31'b0, err_underflow}, 0);
    model_clear();
    @(posedge sb_in_clk);
    #1;
    sb_in_rstL = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the oldest prediction on each falling edge.
  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge sb_in_clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("sb_issue0", {31'b0, issue0}, {31'b0, m.i0});
        chk("sb_issue1", {31'b0, issue1}, {31'b0, m.i1});
        chk("sb_busy", busy_vec, m.busy);
        chk("sb_stall", stall_cnt, m.stall);
        chk("sb_err", {31'b0, err_underflow}, {31'b0, m.err});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      id0_valid = ($urandom_range(0, 9) < 8);
      id0_rs1 = 5'($urandom_range(0, 7)); id0_rs2 = 5'($urandom_range(0, 7));
      id0_we = ($urandom_range(0, 9) < 6); id0_rd = 5'($urandom_range(0, 7));
      id1_valid = ($urandom_range(0, 9) < 8);
      id1_rs1 = 5'($urandom_range(0, 7)); id1_rs2 = 5'($urandom_range(0, 7));
      id1_we = ($urandom_range(0, 9) < 6); id1_rd = 5'($urandom_range(0, 7));
      ex_ready = ($urandom_range(0, 9) < 9);
      wb0_we = ($urandom_range(0, 9) < 4); wb0_rd = 5'($urandom_range(0, 7));
      wb1_we = ($urandom_range(0, 9) < 3); wb1_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
  endtask

  initial begin
    idle();
    model_clear();
    sb_in_rstL = 1'b0;
    #2;
    chk("reset_issue0", {31'b0, issue0}, 0);
    chk("reset_issue1", {31'b0, issue1}, 0);
    chk("reset_busy", busy_vec, 0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_err", {31'b0, err_underflow}, 0);
    @(posedge sb_in_clk);
    #1;
    sb_in_rstL = 1'b1;

    // Single write to r5 issues, then r5 shows busy.
    idle(); ex_ready = 1; id0_valid = 1; id0_we = 1; id0_rd = 5;
    #1 chk("t1_issue0", {31'b0, issue0}, 1);
    step();
    idle(); ex_ready = 1; id0_valid = 1; id0_rs1 = 5;
    #1 chk("t1_busy5", {31'b0, busy_vec[5]}, 1);
    repeat (3) step();
    chk("t2_stall3", stall_cnt, 3);
    wb0_we = 1; wb0_rd = 5;
    #1 chk("t2_wb_cycle", {31'b0, issue0}, {31'b0, BYP});
    step();
    wb0_we = 0;
    #1 chk("t2_after_wb", {31'b0, issue0}, 1);
    step();

    // Intra-pair RAW blocks lane 1; independent lane 1 issues.
    idle(); ex_ready = 1; id0_valid = 1; id0_we = 1; id0_rd = 3;
    id1_valid = 1; id1_rs2 = 3;
    #1 chk("t3_raw_i0", {31'b0, issue0}, 1);
    chk("t3_raw_i1", {31'b0, issue1}, 0);
    step();
    id1_rs2 = 4;
    #1 chk("t3_indep_i1", {31'b0, issue1}, 1);
    step();
    idle(); wb0_we = 1; wb0_rd = 3; wb1_we = 1; wb1_rd = 3;
    step();

    // WAW pair to r7, then a double writeback drains it.
    idle(); ex_ready = 1; id0_valid = 1; id0_we = 1; id0_rd = 7;
    id1_valid = 1; id1_we = 1; id1_rd = 7;
    #1 chk("t4_i0", {31'b0, issue0}, 1);
    chk("t4_i1", {31'b0, issue1}, 1);
    step();
    idle(); wb0_we = 1; wb0_rd = 7; wb1_we = 1; wb1_rd = 7;
    #1 chk("t4_busy7", {31'b0, busy_vec[7]}, 1);
    step();
    idle();
    #1 chk("t4_clear7", {31'b0, busy_vec[7]}, 0);
    step();

    // Saturated counter on r9 blocks further writes; underflow on r12.
    idle(); ex_ready = 1; id0_valid = 1; id0_we = 1; id0_rd = 9;
    repeat (3) step();
    #1 chk("t5_full", {31'b0, issue0}, 0);
    step();
    wb0_we = 1; wb0_rd = 9;
    step();
    wb0_we = 0;
    #1 chk("t5_reopen", {31'b0, issue0}, 1);
    step();
    idle(); wb0_we = 1; wb0_rd = 12;
    step();
    idle();
    #1 chk("t5_err", {31'b0, err_underflow}, 1);
    repeat (2) step();
    chk("t5_err_sticky", {31'b0, err_underflow}, 1);

    reset_mid();

    // Flush with same-cycle writebacks clears everything, no error.
    idle(); ex_ready = 1; id0_valid = 1; id0_we = 1; id0_rd = 10;
    id1_valid = 1; id1_we = 1; id1_rd = 11;
    step();
    id0_rd = 12; id1_rd = 13;
    step();
    idle(); flush = 1; ex_ready = 1; id0_valid = 1; id1_valid = 1;
    wb0_we = 1; wb0_rd = 20; wb1_we = 1; wb1_rd = 10;
    #1 chk("t6_flush_i0", {31'b0, issue0}, 0);
    chk("t6_flush_i1", {31'b0, issue1}, 0);
    step();
    idle();
    #1 chk("t6_busy0", busy_vec, 0);
    chk("t6_err0", {31'b0, err_underflow}, 0);
    step();

    // Build a nonzero stall count, then clear it asynchronously.
    idle(); ex_ready = 1; id0_valid = 1; id0_we = 1; id0_rd = 15;
    step();
    id0_we = 0; id0_rs1 = 15;
    repeat (2) step();
    chk("t7_pre_stall", stall_cnt, 2);
    reset_mid();

    rand_phase(400);
    reset_mid();
    rand_phase(400);
    reset_mid();
    rand_phase(400);
    idle();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge sb_in_clk);
    chk("drain", q.size(), 0);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
